// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle multiply/divide responder.
// Shift-add multiply and restoring divide on operand magnitudes, with signs
// applied at the end. One iteration per clock, WIDTH iterations per operation.
module seq_muldiv #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               op_i,
    input  logic               sign_i,
    input  logic [WIDTH-1:0]   data1_i,
    input  logic [WIDTH-1:0]   data2_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div0_o,
    output logic               ovf_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic               qneg_q, qneg_d;   // quotient / product is negative
    logic               rneg_q, rneg_d;   // remainder is negative
    logic [AW-1:0]      acc_q, acc_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               div0_q, div0_d;
    logic               ovf_q, ovf_d;

    // Datapath helpers
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [AW-1:0]      mul_step;
    logic [AW-1:0]      div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [AW-1:0]      div_step;
    logic [2*WIDTH-1:0] prod_mag;
    logic [WIDTH-1:0]   quo_mag, rem_mag;
    logic               div_ovf;

    assign abs_a = (sign_q && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b = (sign_q && b_q[WIDTH-1]) ? -b_q : b_q;

    // Multiply: acc = {partial product high (W+1), multiplier low (W)}; add, then shift right.
    assign mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, ma_q};
    assign mul_step = acc_q[0] ? ({mul_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);

    // Divide: acc = {partial remainder (W+1), dividend/quotient (W)}; shift left, trial subtract.
    assign div_shift = acc_q << 1;
    assign div_ge    = div_shift[2*WIDTH:WIDTH] >= {1'b0, mb_q};
    assign div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, mb_q};
    assign div_step  = div_ge ? ({div_diff, div_shift[WIDTH-1:0]} | AW'(1)) : div_shift;

    assign prod_mag = acc_q[2*WIDTH-1:0];
    assign quo_mag  = acc_q[WIDTH-1:0];
    assign rem_mag  = acc_q[2*WIDTH-1:WIDTH];
    assign div_ovf  = sign_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    // Next-state, datapath iteration and result formation
    always_comb begin
        // NOTE: every _d defaults to its _q so no path leaves a signal unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_d   = sign_q;
        a_d      = a_q;
        b_d      = b_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        result_d = result_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    sign_d  = sign_i;
                    a_d     = data1_i;
                    b_d     = data2_i;
                    state_d = PREP;
                end
            end
            PREP: begin
                ma_d    = abs_a;
                mb_d    = abs_b;
                qneg_d  = sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d  = sign_q && a_q[WIDTH-1];
                acc_d   = op_q ? {{(WIDTH+1){1'b0}}, abs_a} : {{(WIDTH+1){1'b0}}, abs_b};
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                acc_d = op_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (!op_q) begin
                    result_d = qneg_q ? -prod_mag : prod_mag;
                    div0_d   = 1'b0;
                    ovf_d    = 1'b0;
                end else if (b_q == '0) begin
                    result_d = {a_q, {WIDTH{1'b1}}};
                    div0_d   = 1'b1;
                    ovf_d    = 1'b0;
                end else begin
                    result_d = {(rneg_q ? -rem_mag : rem_mag), (qneg_q ? -quo_mag : quo_mag)};
                    div0_d   = 1'b0;
                    ovf_d    = div_ovf;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            sign_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o   = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign div0_o   = div0_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv (WIDTH = 4): directed vector table,
// hand-written corner sequences and randomized operations against an
// arithmetic reference model.
module tb_seq_muldiv;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic         op_i;
    logic         sign_i;
    logic [W-1:0] data1_i;
    logic [W-1:0] data2_i;
    logic         busy_o;
    logic         done_o;
    logic [2*W-1:0] result_o;
    logic         div0_o;
    logic         ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    seq_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .sign_i   (sign_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .div0_o   (div0_o),
        .ovf_o    (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        bit           op;
        bit           sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] res;
        bit           div0;
        bit           ovf;
    } vec_t;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           div0;
        logic           ovf;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the interpreted operands.
    function automatic exp_t model(input bit op, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sa, sb, p, q, r;
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        e.div0 = 1'b0;
        e.ovf  = 1'b0;
        if (!op) begin
            p = sa * sb;
            e.res = (2*W)'(p);
        end else if (b == 0) begin
            e.res  = {a, {W{1'b1}}};
            e.div0 = 1'b1;
        end else if (sgn && sa == -(1 << (W-1)) && sb == -1) begin
            e.res = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
            e.ovf = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.res = {W'(r), W'(q)};
        end
        return e;
    endfunction

    // Launch one operation from a falling edge, follow it to done, and return
    // what was seen. disturb: pulse start and scramble inputs mid-flight.
    // start_in_done: hold start high through the DONE cycle (must be ignored).
    task automatic run_op(input bit op, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb, input bit start_in_done,
                          output logic [2*W-1:0] res, output logic d0, output logic ov,
                          output int lat, output int busy_n);
        logic [2*W-1:0] prev;
        bit held;
        bit got;
        prev = result_o;
        held = 1'b1;
        got = 1'b0;
        lat = -1;
        busy_n = 0;
        res = '0;
        d0 = 1'b0;
        ov = 1'b0;
        op_i = op;
        sign_i = sgn;
        data1_i = a;
        data2_i = b;
        start_i = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 30 && !got; j++) begin
            @(negedge clk);
            if (j == 0) start_i = 1'b0;
            if (done_o) begin
                got = 1'b1;
                lat = j;
                res = result_o;
                d0 = div0_o;
                ov = ovf_o;
                check("busy_low_at_done", busy_o, 0);
            end else begin
                if (busy_o) busy_n++;
                if (result_o !== prev) held = 1'b0;
            end
            if (disturb && j == 2) begin
                start_i = 1'b1;
                op_i = ~op;
                sign_i = ~sgn;
                data1_i = ~a;
                data2_i = a ^ b ^ 4'h5;
            end
            if (disturb && j == 3) start_i = 1'b0;
        end
        if (!got) check("done_timeout", 0, 1);
        check("result_held_while_busy", held, 1);
        if (start_in_done) start_i = 1'b1;
        @(negedge clk);
        check("idle_after_done", {busy_o, done_o}, 0);
        start_i = 1'b0;
    endtask

    task automatic op_and_check(input string name, input bit op, input bit sgn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input exp_t e, input bit disturb, input bit start_in_done);
        logic [2*W-1:0] res;
        logic d0, ov;
        int lat, busy_n;
        run_op(op, sgn, a, b, disturb, start_in_done, res, d0, ov, lat, busy_n);
        check({name, "_result"}, res, e.res);
        check({name, "_div0"}, d0, e.div0);
        check({name, "_ovf"}, ov, e.ovf);
        check({name, "_latency"}, lat, 6);
        check({name, "_busy_cycles"}, busy_n, 6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        exp_t e;
        bit saw_done;
        bit saw_busy;
        bit rop, rsgn;
        logic [W-1:0] ra, rb;

        vecs[0] = '{"smul_m3x5",   1'b0, 1'b1, 4'hD, 4'h5, 8'hF1, 1'b0, 1'b0};
        vecs[1] = '{"umul_15x15",  1'b0, 1'b0, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0};
        vecs[2] = '{"smul_m8xm8",  1'b0, 1'b1, 4'h8, 4'h8, 8'h40, 1'b0, 1'b0};
        vecs[3] = '{"udiv_13_4",   1'b1, 1'b0, 4'hD, 4'h4, 8'h13, 1'b0, 1'b0};
        vecs[4] = '{"sdiv_7_m2",   1'b1, 1'b1, 4'h7, 4'hE, 8'h1D, 1'b0, 1'b0};
        vecs[5] = '{"sdiv_m7_2",   1'b1, 1'b1, 4'h9, 4'h2, 8'hFD, 1'b0, 1'b0};
        vecs[6] = '{"udiv_9_0",    1'b1, 1'b0, 4'h9, 4'h0, 8'h9F, 1'b1, 1'b0};
        vecs[7] = '{"sdiv_m8_m1",  1'b1, 1'b1, 4'h8, 4'hF, 8'h08, 1'b0, 1'b1};
        vecs[8] = '{"umul_clears", 1'b0, 1'b0, 4'h3, 4'h2, 8'h06, 1'b0, 1'b0};
        vecs[9] = '{"sdiv_m8_0",   1'b1, 1'b1, 4'h8, 4'h0, 8'h8F, 1'b1, 1'b0};

        rst = 1'b1;
        start_i = 1'b0;
        op_i = 1'b0;
        sign_i = 1'b0;
        data1_i = '0;
        data2_i = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy_o, done_o, result_o, div0_o, ovf_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            e.res  = vecs[i].res;
            e.div0 = vecs[i].div0;
            e.ovf  = vecs[i].ovf;
            op_and_check(vecs[i].name, vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, e, 1'b0, 1'b0);
        end

        // Start and operand changes mid-flight are ignored
        e = '{8'h13, 1'b0, 1'b0};
        op_and_check("disturbed_udiv", 1'b1, 1'b0, 4'hD, 4'h4, e, 1'b1, 1'b0);

        // Start held through DONE is ignored; start on the following cycle is accepted
        e = '{8'hF1, 1'b0, 1'b0};
        op_and_check("start_in_done", 1'b0, 1'b1, 4'hD, 4'h5, e, 1'b0, 1'b1);
        e = '{8'h40, 1'b0, 1'b0};
        op_and_check("back_to_back", 1'b0, 1'b1, 4'h8, 4'h8, e, 1'b0, 1'b0);

        // Leave flags set, then reset in the third RUN cycle of a new operation
        e = '{8'h9F, 1'b1, 1'b0};
        op_and_check("pre_reset_div0", 1'b1, 1'b0, 4'h9, 4'h0, e, 1'b0, 1'b0);
        op_i = 1'b0;
        sign_i = 1'b0;
        data1_i = 4'h7;
        data2_i = 4'h3;
        start_i = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) start_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("reset_mid_busy", busy_o, 0);
        check("reset_mid_done", done_o, 0);
        check("reset_mid_result", result_o, 0);
        check("reset_mid_flags", {div0_o, ovf_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_o) saw_done = 1'b1;
            if (busy_o) saw_busy = 1'b1;
        end
        check("no_done_after_reset", saw_done, 0);
        check("no_busy_after_reset", saw_busy, 0);
        e = '{8'h15, 1'b0, 1'b0};
        op_and_check("after_reset_mul", 1'b0, 1'b0, 4'h7, 4'h3, e, 1'b0, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rop  = 1'($urandom_range(0, 1));
            rsgn = 1'($urandom_range(0, 1));
            ra   = W'($urandom_range(0, 15));
            rb   = W'($urandom_range(0, 15));
            if (i % 10 == 0) rb = 4'h0;
            if (i % 10 == 5) begin
                ra = 4'h8;
                rb = 4'hF;
            end
            e = model(rop, rsgn, ra, rb);
            op_and_check($sformatf("rand%0d_op%0d_s%0d_%h_%h", i, rop, rsgn, ra, rb),
                         rop, rsgn, ra, rb, e, (i % 4 == 0), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
